// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD-to-7-segment path.
// Holds the controller state enum and the segment lookup table.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W_MAX = 6;
  localparam int SEG_W     = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Active-high segments, bit0=a ... bit6=g; non-decimal nibbles blank the digit.
  function automatic logic [SEG_W-1:0] seg_lookup(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dd_seq_ctrl_if.sv
// Start/done handshake plus digit and segment outputs of dd_seq_ctrl.
// The master side is the value producer / display consumer, the slave side is the controller.
interface dd_seq_ctrl_if
  import bcd_pkg::*;
#(
  parameter int BIN_W = 6
);

  logic             in_start;
  logic [BIN_W-1:0] in_Bin;
  logic             out_busy;
  logic             out_done;
  logic [3:0]       out_ones;
  logic [3:0]       out_tens;
  logic [SEG_W-1:0] out_O;
  logic [SEG_W-1:0] out_T;

  modport master (
    output in_start,
    output in_Bin,
    input  out_busy,
    input  out_done,
    input  out_ones,
    input  out_tens,
    input  out_O,
    input  out_T
  );

  modport slave (
    input  in_start,
    input  in_Bin,
    output out_busy,
    output out_done,
    output out_ones,
    output out_tens,
    output out_O,
    output out_T
  );

endinterface

// File: rtl/seg7_dec.sv
// Combinational BCD-to-7-segment decoder, one instance per displayed digit.
module seg7_dec
  import bcd_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  assign seg = seg_lookup(bcd);

endmodule

// File: rtl/dd_seq_ctrl.sv
// Sequential double-dabble converter: one shift/add-3 step per clock, registered BCD digits
// feeding two 7-segment decoders. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module dd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
)(
  input  logic         clk,
  input  logic         rst_n,
  dd_seq_ctrl_if.slave bus
);

  localparam int SCR_W = BIN_W + 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_adj;
  logic [SCR_W-1:0] scratch_next;
  logic [CNT_W-1:0] step;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       ones_q;
  logic [3:0]       tens_q;
  logic [SEG_W-1:0] seg_ones;
  logic [SEG_W-1:0] seg_tens;

  // One double-dabble step: correct every BCD nibble of 5 or more, then shift the whole word.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[BIN_W + 4*d +: 4] >= 4'd5) begin
        scratch_adj[BIN_W + 4*d +: 4] = scratch[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    scratch_next = {scratch_adj[SCR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      scratch <= '0;
      step    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE so back-to-back requests lose no cycle.
        IDLE, DONE: begin
          if (bus.in_start) begin
            scratch <= {{(4*DIGITS){1'b0}}, bus.in_Bin};
            step    <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          step    <= step + 1'b1;
          if (step == LAST_STEP) begin
            ones_q <= scratch_next[BIN_W     +: 4];
            tens_q <= scratch_next[BIN_W + 4 +: 4];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  seg7_dec u_dec_ones (
    .bcd (ones_q),
    .seg (seg_ones)
  );

  seg7_dec u_dec_tens (
    .bcd (tens_q),
    .seg (seg_tens)
  );

  assign bus.out_busy = busy_q;
  assign bus.out_done = done_q;
  assign bus.out_ones = ones_q;
  assign bus.out_tens = tens_q;
  assign bus.out_O    = seg_ones;

`ifdef LEADING_ZERO_BLANK_EN
  assign bus.out_T = (tens_q == 4'd0) ? SEG_BLANK : seg_tens;
`else
  assign bus.out_T = seg_tens;
`endif

endmodule

// File: doc/dd_seq_ctrl.md
# dd_seq_ctrl

Sequential controller for the binary-to-BCD-to-7-segment path. It accepts a binary value under a start/done handshake and runs the double-dabble shift/add-3 algorithm one bit per clock, replacing the combinational converter. It then registers the BCD digits and drives two 7-segment display outputs (ones, tens). It sits between the value producer (counter or timer logic) and the two display pins groups.

## Interface
- BIN_W, default 6: binary input width; BIN_W ≤ 6 is required so the result fits in two digits (max 63).
- DIGITS, default 2: BCD digits produced; fixed at 2 for this block.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_start  in  1  request a conversion of in_Bin; sampled on the rising edge.
- in_Bin  in  BIN_W  binary value; captured only on the accepting edge.
- out_busy  out  1  conversion in progress.
- out_done  out  1  one-cycle pulse; result valid and updated.
- out_ones  out  4  BCD ones digit (registered).
- out_tens  out  4  BCD tens digit (registered).
- out_O  out  7  segments, ones digit; active-high, bit0=a … bit6=g.
- out_T  out  7  segments, tens digit; same encoding.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with in_start=1: capture in_Bin into scratch.
  - Scratch is BIN_W+4·DIGITS bits: BCD field zeroed, binary field loaded.
  - Clear the step counter, set busy, go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble ≥5.
  - Then shift the whole scratch left 1.
  - Increment the counter.
- After BIN_W steps, the final BCD field is written to out_ones/out_tens.
  - out_O/out_T are decoded from those registers.
  - Go to DONE.
- DONE: out_done=1 and out_busy=0 for exactly one cycle. Then go to IDLE, unless in_start=1, which is accepted exactly as in IDLE.
- in_start during SHIFT: ignored, with no queuing. in_Bin changes after the accepting edge have no effect.
- Result registers hold the last result until the next DONE. Nothing else alters them.
- Segment codes 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). A BCD nibble >9 cannot occur; the decoder outputs 00 for it.
- Arithmetic: add-3 per nibble is 4-bit, no carry out of the nibble. Tens is never above 6 for BIN_W=6.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE.
  - out_busy 0, out_done 0.
  - out_ones 0, out_tens 0.
  - out_O 3F.
  - out_T 3F, or 00 with the macro below.
- Accepting edge E0 → out_busy=1 from E0.
- Shifts occur on E1…E_BIN_W.
- out_done=1 and the new digits/segments appear on edge E_BIN_W. For BIN_W=6 that is 6 clocks after acceptance.
- Back-to-back: start held high gives one result every BIN_W+1 cycles.
- Reset asserted mid-conversion:
  - Conversion is aborted and no done is produced.
  - All outputs take their reset values.
  - After deassertion the block is in IDLE and waits for a fresh in_start.
- out_busy and out_done are never high together.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when out_tens==0, out_T=00 (blank). This applies to the reset value as well.
- LEADING_ZERO_BLANK_EN undefined: out_T always shows the decoded digit (3F for 0).
- out_O, out_tens and the handshake behave the same either way.

## Structure
- Package bcd_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Constants BIN_W_MAX=6, SEG_W=7, SEG_BLANK=7'h00.
  - Segment lookup for digits 0–9.
- One sub-module seg7_dec: 4-bit BCD in, 7-bit segments out, purely combinational. It is instantiated twice on the registered digits.
- FSM, counter and scratch register live in dd_seq_ctrl.

## Test plan
- Reset, then in_Bin=23 with a one-cycle in_start → out_done exactly 6 clocks later; tens=2/ones=3; out_T=5B, out_O=4F.
- Start 41, then 0, then 59, back-to-back with start held high → done every 7 cycles with results 4/1 (66/06), 0/0, 5/9 (6D/6F).
  - For 0: out_T=00 with LEADING_ZERO_BLANK_EN, 3F without.
- in_Bin=63 → tens=6, ones=3 (7D/4F). Toggling in_start and in_Bin during busy → ignored, result still 63.
- rst_n low at step 3 of a conversion of 41 → outputs immediately at reset values, no out_done. After release, outputs stay at reset values until a new start.
- Idle hold: after a result of 59, 20 cycles with in_start=0 → outputs unchanged, busy=0, done=0.
